riscv_soc: RTL and testbench

//  Minimal RV32I system: single-cycle core (instance riscv_inst), instruction ROM (rom_inst), data RAM.

---
 rtl/riscv_soc_if.sv | 13 +
 rtl/riscv_soc.sv | 243 ++++++++++++++++++++++++
 tb/tb_riscv_soc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_soc_if.sv
// Data-side memory bus between the RV32I core and the SoC memory map.
// The core drives a byte address with byte enables; the memory side
// returns combinational read data for the same address.
interface riscv_soc_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output be, output we, input rdata);
  modport slave  (input addr, input wdata, input be, input we, output rdata);
endinterface

// File: rtl/riscv_soc.sv
// Minimal RV32I system: a single-cycle core, an instruction ROM that is
// also readable as data, and a byte-writable data RAM.
// Memory map by addr[31:28]: 0x0 ROM (read-only), 0x1 RAM, others read 0.

// Register file: two async read ports, one sync write port, x0 hardwired.
module riscv_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  // Writes to x0 are dropped, so regs[0] keeps its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
endmodule

// Instruction ROM with a fetch port and a data-load port; contents are
// preloaded externally and are never modified by the design.
module riscv_rom #(
  parameter int ROM_WORDS = 4096,
  localparam int AW = $clog2(ROM_WORDS)
) (
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [31:0]   data_a,
  output logic [31:0]   data_b
);
  logic [31:0] rom_mem [0:ROM_WORDS-1];

  assign data_a = rom_mem[addr_a];
  assign data_b = rom_mem[addr_b];
endmodule

// Single-cycle RV32I core: decode, execute, memory and writeback in one cycle.
module riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  riscv_soc_if.master dbus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, wb_val, pc_next, pc_plus4, addr;
  logic        wb_en;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic sub_sra);
    logic signed [31:0] sa, sb, sra_r;
    sa    = a;
    sb    = b;
    sra_r = sa >>> b[4:0];
    case (op)
      3'd0:    alu = sub_sra ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, sa < sb};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = sub_sra ? sra_r : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    br_taken = (a == b);
      3'd1:    br_taken = (a != b);
      3'd4:    br_taken = (sa < sb);
      3'd5:    br_taken = (sa >= sb);
      3'd6:    br_taken = (a < b);
      3'd7:    br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  // Lane select by offset, then sign- or zero-extend by funct3
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd1:    load_ext = {{16{h[15]}}, h};
      3'd4:    load_ext = {24'b0, b};
      3'd5:    load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign alt    = inst[30];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  riscv_regs regs_inst (
    .clk(clk), .rst(rst),
    .ra1(rs1), .ra2(rs2), .wa(rd), .we(wb_en), .wd(wb_val),
    .rd1(rs1_val), .rd2(rs2_val)
  );

  // Decode/execute: unlisted opcodes and funct3 codes fall through as NOPs
  always_comb begin
    pc_plus4   = pc + 32'd4;
    pc_next    = pc_plus4;
    wb_en      = 1'b0;
    wb_val     = '0;
    addr       = rs1_val + imm_i;
    dbus.we    = 1'b0;
    dbus.be    = 4'b0;
    dbus.wdata = '0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; wb_val = pc_plus4; pc_next = pc + imm_j; end
      OP_JALR:  begin wb_en = 1'b1; wb_val = pc_plus4; pc_next = addr & ~32'd1; end
      OP_BRANCH: begin
        if (br_taken(rs1_val, rs2_val, f3)) pc_next = pc + imm_b;
      end
      OP_LOAD: begin
        wb_en  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        wb_val = load_ext(dbus.rdata, addr[1:0], f3);
      end
      OP_STORE: begin
        addr = rs1_val + imm_s;
        case (f3)
          3'd0: begin dbus.we = 1'b1; dbus.be = 4'b0001 << addr[1:0]; dbus.wdata = {4{rs2_val[7:0]}}; end
          3'd1: begin dbus.we = 1'b1; dbus.be = addr[1] ? 4'b1100 : 4'b0011; dbus.wdata = {2{rs2_val[15:0]}}; end
          3'd2: begin dbus.we = 1'b1; dbus.be = 4'b1111; dbus.wdata = rs2_val; end
          default: ;
        endcase
      end
      OP_IMM: begin wb_en = 1'b1; wb_val = alu(rs1_val, imm_i, f3, (f3 == 3'd5) && alt); end
      OP_REG: begin wb_en = 1'b1; wb_val = alu(rs1_val, rs2_val, f3, alt); end
      default: ;
    endcase
    dbus.addr = addr;
  end

  // Program counter: one instruction retires per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end
endmodule

module riscv_soc #(
  parameter int          ROM_WORDS = 4096,
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);
  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);

  riscv_soc_if dbus ();

  logic [31:0] pc, inst, rom_rdata, ram_rdata;
  logic [3:0]  region;
  logic [31:0] ram [0:RAM_WORDS-1];
  logic        unused_addr_bits;

  assign region = dbus.addr[31:28];
  assign unused_addr_bits = ^{pc, dbus.addr};

  riscv_core #(.RESET_PC(RESET_PC)) riscv_inst (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .dbus(dbus)
  );

  riscv_rom #(.ROM_WORDS(ROM_WORDS)) rom_inst (
    .addr_a(pc[ROM_AW+1:2]), .addr_b(dbus.addr[ROM_AW+1:2]),
    .data_a(inst), .data_b(rom_rdata)
  );

  assign ram_rdata = ram[dbus.addr[RAM_AW+1:2]];

  // Load data mux by region; unmapped regions read as zero
  always_comb begin
    case (region)
      4'h0:    dbus.rdata = rom_rdata;
      4'h1:    dbus.rdata = ram_rdata;
      default: dbus.rdata = '0;
    endcase
  end

  // RAM byte-lane writes; stores to ROM or unmapped space are dropped
  always_ff @(posedge clk) begin
    if (dbus.we && region == 4'h1) begin
      for (int i = 0; i < 4; i++)
        if (dbus.be[i]) ram[dbus.addr[RAM_AW+1:2]][8*i +: 8] <= dbus.wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_riscv_soc.sv
// Bench for riscv_soc: small hand-assembled programs are preloaded into
// ROM, run for a fixed number of clocks, and register/pc state is checked.
module tb_riscv_soc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_soc dut (.clk(clk), .rst(rst));

  localparam int LUI = 7'h37, AUIPC = 7'h17, LD = 7'h03, OPI = 7'h13, SYS = 7'h73;

  function automatic logic [31:0] i_t(int op, int f3, int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] r_t(int f7, int f3, int rd, int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs1, int rs2, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs1, int rs2, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(int imm20, int rd, int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  typedef struct {
    string       name;
    int          prog;
    int          cycles;
    int          idx;     // 0..31 register, 32 = pc
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic logic [31:0] probe(int idx);
    if (idx == 32) return dut.riscv_inst.pc;
    return dut.riscv_inst.regs_inst.regs[idx[4:0]];
  endfunction

  task automatic expect_val(string name, int idx, logic [31:0] mask, logic [31:0] exp);
    exp_t e;
    e.name = name; e.idx = idx; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = probe(e.idx) & e.mask;
      n_cmp++;
      if (act !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", e.name, act, e.exp & e.mask);
      end
    end
  endtask

  task automatic load_prog(int id);
    logic [31:0] p[$];
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0;
    case (id)
      1: p = '{i_t(OPI,0,1,0,5), i_t(OPI,0,2,1,-7)};
      2: p = '{i_t(OPI,0,1,0,-1), i_t(OPI,0,2,0,1), b_t(32,1,2,5), b_t(8,2,1,5),
               j_t(24,0), b_t(8,1,2,7), j_t(16,0), i_t(OPI,0,27,0,1),
               i_t(OPI,0,26,0,1), j_t(0,0), i_t(OPI,0,26,0,1), j_t(0,0)};
      3: p = '{u_t(32'h10000,5,LUI), i_t(OPI,0,6,0,-128), s_t(1,5,6,0), i_t(LD,2,7,5,0),
               i_t(LD,0,8,5,1), i_t(LD,4,9,5,1), s_t(2,5,6,1), i_t(LD,1,10,5,2),
               i_t(LD,5,11,5,2), u_t(32'h20000,12,LUI), i_t(LD,2,13,12,0), i_t(LD,2,14,0,0),
               s_t(0,0,6,2), i_t(LD,2,15,0,0), j_t(0,0)};
      4: p = '{j_t(8,1), i_t(OPI,0,20,0,1), i_t(OPI,0,21,0,2)};
      5: p = '{i_t(OPI,0,1,0,9), i_t(7'h67,0,0,1,0)};
      7: p = '{i_t(OPI,0,0,0,1), i_t(OPI,0,4,0,7)};
      8: p = '{32'h00000073, i_t(SYS,2,5,0,32'hB00), 32'h0FF0000F, i_t(OPI,0,6,0,3)};
      9: p = '{i_t(OPI,0,1,0,-1), i_t(OPI,0,2,0,1), r_t(0,0,3,1,2), r_t(32,0,4,0,2),
               r_t(0,2,5,1,2), r_t(0,3,6,1,2), i_t(OPI,1,7,2,31), i_t(OPI,5,8,7,32'h404),
               i_t(OPI,5,9,7,4), r_t(32,5,10,7,2), i_t(OPI,4,11,1,32'h0F0),
               i_t(OPI,7,12,1,32'h7F0), u_t(1,13,AUIPC), r_t(0,1,14,2,7), j_t(0,0)};
      default: p = '{};
    endcase
    foreach (p[i]) dut.rom_inst.rom_mem[i] = p[i];
  endtask

  // Hold reset across a clock edge while loading, release on a falling edge
  task automatic start(int id);
    rst = 1'b1;
    load_prog(id);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lui_word;
    lui_word = u_t(32'h10000, 5, LUI);

    vecs.push_back('{"p1_x1",       1, 2, 1,  32'hFFFFFFFF, 32'h00000005});
    vecs.push_back('{"p1_x2",       1, 2, 2,  32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"p1_x0",       1, 2, 0,  32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"rst_pc",      1, 0, 32, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"rst_x1",      1, 0, 1,  32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"bge_done",    2, 12, 26, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{"bge_pass",    2, 12, 27, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{"bge_pc",      2, 12, 32, 32'hFFFFFFFF, 32'h00000024});
    vecs.push_back('{"lui_x5",      3, 16, 5,  32'hFFFFFFFF, 32'h10000000});
    vecs.push_back('{"lw_lane",     3, 16, 7,  32'h0000FF00, 32'h00008000});
    vecs.push_back('{"lb_sext",     3, 16, 8,  32'hFFFFFFFF, 32'hFFFFFF80});
    vecs.push_back('{"lbu_zext",    3, 16, 9,  32'hFFFFFFFF, 32'h00000080});
    vecs.push_back('{"lh_hi",       3, 16, 10, 32'hFFFFFFFF, 32'hFFFFFF80});
    vecs.push_back('{"lhu_hi",      3, 16, 11, 32'hFFFFFFFF, 32'h0000FF80});
    vecs.push_back('{"ld_unmapped", 3, 16, 13, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"ld_rom",      3, 16, 14, 32'hFFFFFFFF, lui_word});
    vecs.push_back('{"st_rom_drop", 3, 16, 15, 32'hFFFFFFFF, lui_word});
    vecs.push_back('{"jal_link",    4, 1, 1,  32'hFFFFFFFF, 32'h00000004});
    vecs.push_back('{"jal_pc",      4, 1, 32, 32'hFFFFFFFF, 32'h00000008});
    vecs.push_back('{"jal_skip",    4, 3, 20, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"jal_target",  4, 3, 21, 32'hFFFFFFFF, 32'h00000002});
    vecs.push_back('{"jalr_pc",     5, 2, 32, 32'hFFFFFFFF, 32'h00000008});
    vecs.push_back('{"x0_write",    7, 2, 0,  32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"x0_read",     7, 2, 4,  32'hFFFFFFFF, 32'h00000007});
    vecs.push_back('{"sys_pc",      8, 3, 32, 32'hFFFFFFFF, 32'h0000000C});
    vecs.push_back('{"csr_nowb",    8, 4, 5,  32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"after_sys",   8, 4, 6,  32'hFFFFFFFF, 32'h00000003});
    vecs.push_back('{"add_wrap",    9, 15, 3,  32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"sub",         9, 15, 4,  32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{"slt",         9, 15, 5,  32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{"sltu",        9, 15, 6,  32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"slli31",      9, 15, 7,  32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{"srai",        9, 15, 8,  32'hFFFFFFFF, 32'hF8000000});
    vecs.push_back('{"srli",        9, 15, 9,  32'hFFFFFFFF, 32'h08000000});
    vecs.push_back('{"sra",         9, 15, 10, 32'hFFFFFFFF, 32'hC0000000});
    vecs.push_back('{"xori",        9, 15, 11, 32'hFFFFFFFF, 32'hFFFFFF0F});
    vecs.push_back('{"andi",        9, 15, 12, 32'hFFFFFFFF, 32'h000007F0});
    vecs.push_back('{"auipc",       9, 15, 13, 32'hFFFFFFFF, 32'h00001030});
    vecs.push_back('{"sll_amt5",    9, 15, 14, 32'hFFFFFFFF, 32'h00000001});

    foreach (vecs[v]) begin
      start(vecs[v].prog);
      expect_val(vecs[v].name, vecs[v].idx, vecs[v].mask, vecs[v].exp);
      run(vecs[v].cycles);
      drain();
    end

    // Asynchronous reset mid-run, then a rerun that must match the first run
    start(2);
    run(4);
    expect_val("mid_x1_before", 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain();
    #2 rst = 1'b1;
    #1;
    expect_val("async_pc", 32, 32'hFFFFFFFF, 32'h00000000);
    expect_val("async_x1", 1,  32'hFFFFFFFF, 32'h00000000);
    expect_val("async_x2", 2,  32'hFFFFFFFF, 32'h00000000);
    drain();
    @(negedge clk);
    rst = 1'b0;
    run(12);
    expect_val("rerun_done", 26, 32'hFFFFFFFF, 32'h00000001);
    expect_val("rerun_pass", 27, 32'hFFFFFFFF, 32'h00000001);
    expect_val("rerun_x1",   1,  32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_val("rerun_pc",   32, 32'hFFFFFFFF, 32'h00000024);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
